// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared types and constants for the divider / BCD output path.
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int TAMANYO_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV_Q = 2'd1,
        CONV_R = 2'd2,
        FIN    = 2'd3
    } estado_bcd_t;

    // Minimum decimal digits for a bits-wide unsigned value: ceil(bits*log10(2)).
    function automatic int digitos_bcd(input int bits);
        return (bits * 30103 + 99999) / 100000;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_ajuste.sv
`default_nettype none
// ============================================================================
// Module      : bcd_ajuste
// Description : Add-3 correction of every packed BCD digit that is >= 5.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_ajuste #(
    parameter int DIGITOS = 10
) (
    input  logic [4*DIGITOS-1:0] i_bcd,
    output logic [4*DIGITOS-1:0] o_bcd
);

    // Digits are corrected independently; no carry crosses a digit boundary.
    for (genvar g = 0; g < DIGITOS; g++) begin : g_digito
        assign o_bcd[4*g +: 4] = (i_bcd[4*g +: 4] >= 4'd5) ? (i_bcd[4*g +: 4] + 4'd3)
                                                            : i_bcd[4*g +: 4];
    end

endmodule
`default_nettype wire

// File: rtl/conversor_bin_bcd.sv
`default_nettype none
// ============================================================================
// Module      : conversor_bin_bcd
// Description : Sequential double-dabble conversion of quotient then remainder.
// Revision    : 1.0 - initial release
// ============================================================================
module conversor_bin_bcd
    import div_pkg::*;
#(
    parameter int tamanyo = TAMANYO_DEF,
    parameter int DIGITOS = digitos_bcd(tamanyo)
) (
    input  logic                 CLK,
    input  logic                 RSTa,
    input  logic                 Start,
    input  logic [tamanyo-1:0]   Coc,
    input  logic [tamanyo-1:0]   Res,
    output logic [4*DIGITOS-1:0] BCD_Coc,
    output logic [4*DIGITOS-1:0] BCD_Res,
    output logic                 Busy,
    output logic                 Done
);

    localparam int               CW       = $clog2(tamanyo + 1);
    localparam logic [CW-1:0]    C_ULTIMO = CW'(tamanyo - 1);
    localparam logic [CW-1:0]    C_UNO    = CW'(1);

    estado_bcd_t            estado_q, estado_d;
    logic [tamanyo-1:0]     bin_q, bin_d;
    logic [tamanyo-1:0]     res_q, res_d;
    logic [4*DIGITOS-1:0]   acc_q, acc_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [4*DIGITOS-1:0]   bcd_coc_q, bcd_coc_d;
    logic [4*DIGITOS-1:0]   bcd_res_q, bcd_res_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [4*DIGITOS-1:0]   w_ajustado;
    logic [4*DIGITOS-1:0]   w_desplazado;

    bcd_ajuste #(
        .DIGITOS (DIGITOS)
    ) u_ajuste (
        .i_bcd (acc_q),
        .o_bcd (w_ajustado)
    );

    // One double-dabble step: corrected accumulator takes the binary MSB.
    assign w_desplazado = {w_ajustado[4*DIGITOS-2:0], bin_q[tamanyo-1]};

    always_comb begin
        estado_d  = estado_q;
        bin_d     = bin_q;
        res_d     = res_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        bcd_coc_d = bcd_coc_q;
        bcd_res_d = bcd_res_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (estado_q)
            IDLE: begin
                if (Start) begin
                    bin_d    = Coc;
                    res_d    = Res;
                    acc_d    = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    estado_d = CONV_Q;
                end
            end
            CONV_Q: begin
                acc_d = w_desplazado;
                bin_d = {bin_q[tamanyo-2:0], 1'b0};
                cnt_d = cnt_q + C_UNO;
                if (cnt_q == C_ULTIMO) begin
                    bcd_coc_d = w_desplazado;
                    acc_d     = '0;
                    bin_d     = res_q;
                    cnt_d     = '0;
                    estado_d  = CONV_R;
                end
            end
            CONV_R: begin
                acc_d = w_desplazado;
                bin_d = {bin_q[tamanyo-2:0], 1'b0};
                cnt_d = cnt_q + C_UNO;
                if (cnt_q == C_ULTIMO) begin
                    bcd_res_d = w_desplazado;
                    cnt_d     = '0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    estado_d  = FIN;
                end
            end
            FIN: begin
                estado_d = IDLE;
            end
            default: begin
                estado_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RSTa) begin
            estado_q  <= IDLE;
            bin_q     <= '0;
            res_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            bcd_coc_q <= '0;
            bcd_res_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            bin_q     <= bin_d;
            res_q     <= res_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            bcd_coc_q <= bcd_coc_d;
            bcd_res_q <= bcd_res_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign BCD_Coc = bcd_coc_q;
    assign BCD_Res = bcd_res_q;
    assign Busy    = busy_q;
    assign Done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_conversor_bin_bcd.sv
`default_nettype none
// ============================================================================
// Module      : tb_conversor_bin_bcd
// Description : Scoreboard bench for conversor_bin_bcd with a decimal model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conversor_bin_bcd;

    localparam int T = 32;
    localparam int D = 10;

    logic           CLK = 1'b0;
    logic           RSTa;
    logic           Start;
    logic [T-1:0]   Coc;
    logic [T-1:0]   Res;
    logic [4*D-1:0] BCD_Coc;
    logic [4*D-1:0] BCD_Res;
    logic           Busy;
    logic           Done;

    int tests = 0;
    int fails = 0;
    int dones = 0;
    int exp_dones = 0;
    logic [8*D-1:0] exp_q[$];

    always #5 CLK = ~CLK;

    conversor_bin_bcd #(
        .tamanyo (T),
        .DIGITOS (D)
    ) dut (
        .CLK     (CLK),
        .RSTa    (RSTa),
        .Start   (Start),
        .Coc     (Coc),
        .Res     (Res),
        .BCD_Coc (BCD_Coc),
        .BCD_Res (BCD_Res),
        .Busy    (Busy),
        .Done    (Done)
    );

    // Reference: decimal digits by repeated division.
    function automatic logic [4*D-1:0] to_bcd(input longint unsigned v);
        logic [4*D-1:0] r;
        r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [8*D-1:0] act, input logic [8*D-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every Done pulse consumes one expected result.
    always @(negedge CLK) begin
        logic [8*D-1:0] e;
        if (Done === 1'b1) begin
            dones++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL done_unexpected: got Done=1 expected no pending result");
            end else begin
                e = exp_q.pop_front();
                chk("bcd_coc", BCD_Coc, e[8*D-1:4*D]);
                chk("bcd_res", BCD_Res, e[4*D-1:0]);
            end
        end
    end

    task automatic conv(input logic [T-1:0] c, input logic [T-1:0] r, input bit intrude);
        int n;
        int busy_n;
        @(negedge CLK);
        Coc   = c;
        Res   = r;
        Start = 1'b1;
        exp_q.push_back({to_bcd(longint'(c)), to_bcd(longint'(r))});
        exp_dones++;
        @(posedge CLK);
        #1;
        Start  = 1'b0;
        Coc    = $urandom;
        Res    = $urandom;
        busy_n = (Busy === 1'b1) ? 1 : 0;
        n      = 0;
        while (n < 200) begin
            if (intrude && n == 10) begin
                Start = 1'b1;
                Coc   = ~c;
                Res   = ~r;
            end
            if (intrude && n == 11) Start = 1'b0;
            @(posedge CLK);
            #1;
            n++;
            if (Done === 1'b1) break;
            if (Busy === 1'b1) busy_n++;
        end
        chk("latency", 80'(n), 80'(64));
        chk("busy_cycles", 80'(busy_n), 80'(64));
        chk("busy_in_fin", 80'(Busy), 80'(0));
        @(posedge CLK);
        #1;
        chk("done_width", 80'(Done), 80'(0));
    endtask

    initial begin
        RSTa  = 1'b1;
        Start = 1'b0;
        Coc   = '0;
        Res   = '0;
        repeat (2) @(posedge CLK);
        #1;
        RSTa = 1'b0;
        chk("reset_coc", 80'(BCD_Coc), 80'(0));
        chk("reset_res", 80'(BCD_Res), 80'(0));
        chk("reset_busy", 80'(Busy), 80'(0));
        chk("reset_done", 80'(Done), 80'(0));

        conv(32'd0, 32'd0, 1'b0);
        conv(32'd123, 32'd45, 1'b0);
        conv(32'hFFFF_FFFF, 32'd99999, 1'b0);
        conv(32'd14, 32'd2, 1'b0);
        conv(32'd987654321, 32'd5555, 1'b1);

        // Abort mid-conversion: no result is expected from this one.
        @(negedge CLK);
        Coc   = 32'd31415926;
        Res   = 32'd27182;
        Start = 1'b1;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        repeat (19) @(posedge CLK);
        #1;
        RSTa = 1'b1;
        @(posedge CLK);
        #1;
        RSTa = 1'b0;
        chk("abort_coc", 80'(BCD_Coc), 80'(0));
        chk("abort_res", 80'(BCD_Res), 80'(0));
        chk("abort_busy", 80'(Busy), 80'(0));
        chk("abort_done", 80'(Done), 80'(0));
        repeat (80) @(posedge CLK);

        conv(32'd100 / 32'd7, 32'd100 % 32'd7, 1'b0);

        for (int i = 0; i < 20; i++) begin
            if (i % 3 == 0) conv(32'($urandom_range(0, 9999)), 32'($urandom_range(0, 99)), 1'b0);
            else            conv($urandom, $urandom, 1'b0);
        end

        repeat (5) @(posedge CLK);
        #1;
        chk("queue_empty", 80'(exp_q.size()), 80'(0));
        chk("done_count", 80'(dones), 80'(exp_dones));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
